// File: rtl/mult_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mult_seq_ctrl                                              |
// | Description : Time-shares one external 8x8 unsigned multiplier to build  |
// |               a 16*OP_BYTES-bit product over valid/ready handshakes.     |
// |               Optional zero-byte skipping: MULT_SEQ_ZERO_SKIP_EN.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mult_seq_ctrl #(
    parameter int OP_BYTES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*OP_BYTES-1:0]   op_a,
    input  logic [8*OP_BYTES-1:0]   op_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [16*OP_BYTES-1:0]  product,
    output logic                    busy,
    output logic [7:0]              mul_mcand,
    output logic [7:0]              mul_mplier,
    input  logic [15:0]             mul_prod
);

    localparam int OW = 8 * OP_BYTES;
    localparam int PW = 16 * OP_BYTES;
    localparam int IW = (OP_BYTES > 1) ? $clog2(OP_BYTES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [OW-1:0]       r_a;
    logic [OW-1:0]       r_b;
    logic [PW-1:0]       r_acc;
    logic [PW-1:0]       w_acc_nxt;
    logic [PW-1:0]       w_pp;
    logic [IW-1:0]       r_i;
    logic [IW-1:0]       r_j;
    logic [IW-1:0]       w_i_nxt;
    logic [IW-1:0]       w_j_nxt;
    logic                w_load;

    logic [OP_BYTES-1:0] w_a_nz;
    logic [OP_BYTES-1:0] w_b_nz;
    logic [OP_BYTES-1:0] w_in_a_nz;
    logic [OP_BYTES-1:0] w_in_b_nz;
    logic [IW-1:0]       w_in_first_i;
    logic [IW-1:0]       w_in_first_j;
    logic [IW-1:0]       w_wrap_i;
    logic [IW-1:0]       w_step_i;
    logic [IW-1:0]       w_step_j;
    logic                w_has_step_i;
    logic                w_has_step_j;

    // Byte-visit masks: all ones when skipping is off, so the same walker
    // below degenerates into the plain i-inner, j-outer sweep.
    for (genvar k = 0; k < OP_BYTES; k++) begin : g_nz
`ifdef MULT_SEQ_ZERO_SKIP_EN
        assign w_a_nz[k]    = |r_a[8*k +: 8];
        assign w_b_nz[k]    = |r_b[8*k +: 8];
        assign w_in_a_nz[k] = |op_a[8*k +: 8];
        assign w_in_b_nz[k] = |op_b[8*k +: 8];
`else
        assign w_a_nz[k]    = 1'b1;
        assign w_b_nz[k]    = 1'b1;
        assign w_in_a_nz[k] = 1'b1;
        assign w_in_b_nz[k] = 1'b1;
`endif
    end

    // Descending scan leaves the lowest qualifying index in each result.
    always_comb begin
        w_in_first_i = '0;
        w_in_first_j = '0;
        w_wrap_i     = '0;
        w_step_i     = '0;
        w_step_j     = '0;
        w_has_step_i = 1'b0;
        w_has_step_j = 1'b0;
        for (int k = OP_BYTES - 1; k >= 0; k--) begin
            if (w_in_a_nz[k]) w_in_first_i = IW'(k);
            if (w_in_b_nz[k]) w_in_first_j = IW'(k);
            if (w_a_nz[k])    w_wrap_i     = IW'(k);
            if (w_a_nz[k] && (k > int'(r_i))) begin
                w_step_i     = IW'(k);
                w_has_step_i = 1'b1;
            end
            if (w_b_nz[k] && (k > int'(r_j))) begin
                w_step_j     = IW'(k);
                w_has_step_j = 1'b1;
            end
        end
    end

    assign w_pp = PW'(mul_prod) << (8 * (int'(r_i) + int'(r_j)));

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_load    = 1'b1;
                    w_acc_nxt = '0;
                    w_i_nxt   = w_in_first_i;
                    w_j_nxt   = w_in_first_j;
                    // A zero operand has no passes to issue; finish at once.
                    if ((|w_in_a_nz) && (|w_in_b_nz)) w_state_nxt = S_CALC;
                    else                              w_state_nxt = S_DONE;
                end
            end
            S_CALC: begin
                w_acc_nxt = r_acc + w_pp;
                if (w_has_step_i) begin
                    w_i_nxt = w_step_i;
                end else begin
                    w_i_nxt = w_wrap_i;
                    if (w_has_step_j) w_j_nxt     = w_step_j;
                    else              w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_i     <= '0;
            r_j     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_i     <= w_i_nxt;
            r_j     <= w_j_nxt;
            if (w_load) begin
                r_a <= op_a;
                r_b <= op_b;
            end
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign busy       = (r_state == S_CALC) || (r_state == S_DONE);
    assign product    = r_acc;
    assign mul_mcand  = (r_state == S_CALC) ? r_a[8*r_i +: 8] : 8'd0;
    assign mul_mplier = (r_state == S_CALC) ? r_b[8*r_j +: 8] : 8'd0;

endmodule
`default_nettype wire
